tt_sel_driver: RTL and testbench
================================

TT_SEL_DRIVER -- requirements
Module: tt_sel_driver

Interface
REQ-001 Parameter ADDR_W, default 10: width of the design-select address; 2^ADDR_W SHALL cover G_X*G_Y user modules.
REQ-002 Parameter PULSE_W, default 4: width of every control-line phase, in clk cycles; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state SHALL be registered on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  selection request present.
REQ-006 req_ready  output  1  block can accept a request (high only in IDLE).
REQ-007 req_addr  input  ADDR_W  target design index (number of increment pulses).
REQ-008 req_ena  input  1  value to drive on ctrl_ena once selection completes.
REQ-009 ctrl_sel_rst_n  output  1  selector reset toward the controller pad, active-low.
REQ-010 ctrl_sel_inc  output  1  selector increment toward the controller pad; rising edge = +1.
REQ-011 ctrl_ena  output  1  design enable toward the controller pad.
REQ-012 busy  output  1  sequence in progress (not IDLE).
REQ-013 done  output  1  single-cycle pulse when a sequence completes.

Function
REQ-014 The block SHALL drive the controller's select protocol: it resets the selector, issues req_addr increment pulses, then drives ctrl_ena.
REQ-015 States SHALL be IDLE, RST_LO, RST_HI, INC_HI, INC_LO, FINISH.
REQ-016 Handshake: a request SHALL be accepted on a clk edge where req_valid and req_ready are both high; req_addr and req_ena SHALL be latched on that edge.
REQ-017 req_ready SHALL equal (state == IDLE), registered; requests presented outside IDLE SHALL be ignored and not queued.
REQ-018 On accept: the next state SHALL be RST_LO, ctrl_ena SHALL go 0, and the latched addr SHALL be loaded into the increment counter.
REQ-019 RST_LO SHALL drive ctrl_sel_rst_n=0 for exactly PULSE_W cycles, then go to RST_HI.
REQ-020 RST_HI SHALL drive ctrl_sel_rst_n=1, ctrl_sel_inc=0 for PULSE_W cycles; it SHALL then go to INC_HI if the counter is nonzero, else to FINISH.
REQ-021 INC_HI SHALL drive ctrl_sel_inc=1 for PULSE_W cycles, then go to INC_LO.
REQ-022 INC_LO SHALL drive ctrl_sel_inc=0 for PULSE_W cycles and decrement the counter on exit; it SHALL go to INC_HI if the decremented value is nonzero, else to FINISH.
REQ-023 FINISH SHALL last one cycle: done=1, ctrl_ena=latched req_ena; the next state SHALL be IDLE.
REQ-024 ctrl_ena SHALL hold its FINISH value through IDLE until the next accept.
REQ-025 All ctrl_* outputs SHALL be driven directly from flops (no combinational paths to pads).
REQ-026 Latency: done SHALL assert exactly 2*PULSE_W*(1+req_addr)+1 cycles after the accept edge.
REQ-027 Phase timer: a down-counter of ceil(log2(PULSE_W+1)) bits, reloaded with PULSE_W-1 on each state entry.
REQ-028 Increment counter: ADDR_W bits; req_addr = 2^ADDR_W-1 SHALL be handled without wrap; req_addr=0 SHALL issue no inc pulse.
REQ-029 The case where req_valid is high in the same cycle as done SHALL NOT be accepted; acceptance SHALL occur no earlier than the following edge, once in IDLE.

Reset
REQ-030 While rst_n=0: state=IDLE, ctrl_sel_rst_n=0, ctrl_sel_inc=0, ctrl_ena=0, done=0, busy=0, req_ready=0, counters=0.
REQ-031 On the first clk edge after rst_n deasserts: ctrl_sel_rst_n=1 and req_ready=1.
REQ-032 Reset asserted mid-sequence SHALL abort immediately to the REQ-030 values; no done pulse SHALL be issued.

Verification (PULSE_W=2)
REQ-033 Request addr=3, ena=1 -> rst_n low 2 cycles, high 2 cycles, then exactly 3 inc pulses each 2 high / 2 low; done and ctrl_ena=1 at cycle 17 after accept.
REQ-034 Request addr=0, ena=1 -> no inc pulses; done at cycle 5; ctrl_ena=1.
REQ-035 Back-to-back: req_valid held high across two requests -> second accepted only after the done cycle; ctrl_ena drops to 0 on the second accept.
REQ-036 Assert rst_n during INC_HI of an addr=5 request -> all outputs take REQ-030 values asynchronously; no done; clean addr=1 sequence afterwards.
REQ-037 Request addr=1023 -> exactly 1023 inc pulses counted by the bench; done at cycle 4097.
REQ-038 Request ena=0 after a previous ena=1 -> ctrl_ena=0 from accept onward, still 0 after done.

Source files
------------

// File: rtl/tt_sel_driver_if.sv
// Request handshake between a selection client and tt_sel_driver.
interface tt_sel_driver_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ena;

    modport master (output req_valid, output req_addr, output req_ena, input  req_ready);
    modport slave  (input  req_valid, input  req_addr, input  req_ena, output req_ready);
endinterface

// File: rtl/tt_sel_driver.sv
// Drives the controller select protocol: selector reset, req_addr increment
// pulses of PULSE_W-cycle phases, then the design enable.
module tt_sel_driver #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned PULSE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tt_sel_driver_if.slave        req,
    output logic                  ctrl_sel_rst_n,
    output logic                  ctrl_sel_inc,
    output logic                  ctrl_ena,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned TMR_W = $clog2(PULSE_W + 1);
    localparam logic [TMR_W-1:0] TMR_RLD = TMR_W'(PULSE_W - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RST_LO = 3'd1;
    localparam logic [2:0] RST_HI = 3'd2;
    localparam logic [2:0] INC_HI = 3'd3;
    localparam logic [2:0] INC_LO = 3'd4;
    localparam logic [2:0] FINISH = 3'd5;

    logic [2:0]        state, state_d;
    logic [TMR_W-1:0]  tmr, tmr_d;
    logic [ADDR_W-1:0] cnt, cnt_d;
    logic              ena_lat, ena_lat_d;
    logic              ctrl_ena_d;
    logic              phase_end;

    assign phase_end = (tmr == '0);

    // Next-state, phase timer and increment counter.
    always_comb begin
        state_d    = state;
        tmr_d      = tmr;
        cnt_d      = cnt;
        ena_lat_d  = ena_lat;
        ctrl_ena_d = ctrl_ena;

        case (state)
            IDLE: begin
                if (req.req_valid && req.req_ready) begin
                    state_d    = RST_LO;
                    cnt_d      = ADDR_W'(req.req_addr);
                    ena_lat_d  = req.req_ena;
                    ctrl_ena_d = 1'b0;
                end
            end
            RST_LO: if (phase_end) state_d = RST_HI;
            RST_HI: if (phase_end) state_d = (cnt != '0) ? INC_HI : FINISH;
            INC_HI: if (phase_end) state_d = INC_LO;
            INC_LO: begin
                if (phase_end) begin
                    cnt_d   = cnt - ADDR_W'(1);
                    // Compare pre-decrement value so addr = all-ones never wraps.
                    state_d = (cnt != ADDR_W'(1)) ? INC_HI : FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Every state entry restarts the phase timer.
        if (state_d != state) begin
            tmr_d = TMR_RLD;
        end else if (tmr != '0) begin
            tmr_d = tmr - TMR_W'(1);
        end

        // FINISH lasts one cycle, so this fires only on its entry.
        if (state_d == FINISH) begin
            ctrl_ena_d = ena_lat;
        end
    end

    // State and all pad-facing outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            tmr            <= '0;
            cnt            <= '0;
            ena_lat        <= 1'b0;
            ctrl_sel_rst_n <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b0;
            req.req_ready  <= 1'b0;
        end else begin
            state          <= state_d;
            tmr            <= tmr_d;
            cnt            <= cnt_d;
            ena_lat        <= ena_lat_d;
            ctrl_sel_rst_n <= (state_d != RST_LO);
            ctrl_sel_inc   <= (state_d == INC_HI);
            ctrl_ena       <= ctrl_ena_d;
            done           <= (state_d == FINISH);
            busy           <= (state_d != IDLE);
            req.req_ready  <= (state_d == IDLE);
        end
    end
endmodule

// File: tb/tb_tt_sel_driver.sv
// Directed bench for tt_sel_driver with PULSE_W=2, ADDR_W=10.
module tb_tt_sel_driver;
    logic clk;
    logic rst_n;
    logic ctrl_sel_rst_n;
    logic ctrl_sel_inc;
    logic ctrl_ena;
    logic busy;
    logic done;
    int   vecs;
    int   errs;

    tt_sel_driver_if #(.ADDR_W(10)) bus ();

    tt_sel_driver #(.ADDR_W(10), .PULSE_W(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (bus),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_ena       (ctrl_ena),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycle 1 is the first cycle after the accept edge; exp_done is the cycle
    // in which done is observed high.
    task automatic run_seq(input int a, input logic e, input bit hold,
                           input int na, input logic ne, input int exp_done);
        int   c;
        int   pulses;
        int   shape_err;
        logic prev_inc;
        logic exp_inc;
        logic exp_rn;
        bit   seen;
        bus.req_valid = 1'b1;
        bus.req_addr  = 10'(a);
        bus.req_ena   = e;
        tick();
        if (hold) begin
            bus.req_addr = 10'(na);
            bus.req_ena  = ne;
        end else begin
            bus.req_valid = 1'b0;
        end
        chk("accept_ena_low", int'(ctrl_ena), 0);
        chk("accept_busy", int'(busy), 1);
        chk("accept_ready", int'(bus.req_ready), 0);
        c = 1; pulses = 0; shape_err = 0; prev_inc = 1'b0; seen = 1'b0;
        while (!seen && c < 5000) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                exp_inc = (c >= 5) && (c <= 4 + 4 * a) && (((c - 5) % 4) < 2);
                exp_rn  = (c > 2);
                if (ctrl_sel_inc !== exp_inc) shape_err++;
                if (ctrl_sel_rst_n !== exp_rn) shape_err++;
                if (ctrl_sel_inc && !prev_inc) pulses++;
                prev_inc = ctrl_sel_inc;
                tick();
                c++;
            end
        end
        chk("done_cycle", c, exp_done);
        chk("inc_pulses", pulses, a);
        chk("wave_shape", shape_err, 0);
        chk("finish_ena", int'(ctrl_ena), int'(e));
        chk("finish_ready", int'(bus.req_ready), 0);
        chk("finish_inc", int'(ctrl_sel_inc), 0);
        tick();
        chk("post_done", int'(done), 0);
        chk("post_ready", int'(bus.req_ready), 1);
        chk("post_busy", int'(busy), 0);
        chk("hold_ena", int'(ctrl_ena), int'(e));
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_ena   = 1'b0;
        #3;
        chk("rst_sel_rst_n", int'(ctrl_sel_rst_n), 0);
        chk("rst_ready", int'(bus.req_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ena", int'(ctrl_ena), 0);
        tick();
        chk("rst_edge_sel_rst_n", int'(ctrl_sel_rst_n), 0);
        chk("rst_edge_done", int'(done), 0);
        rst_n = 1'b1;
        tick();
        chk("rel_sel_rst_n", int'(ctrl_sel_rst_n), 1);
        chk("rel_ready", int'(bus.req_ready), 1);
        chk("rel_inc", int'(ctrl_sel_inc), 0);

        run_seq(3, 1'b1, 1'b0, 0, 1'b0, 17);
        run_seq(0, 1'b1, 1'b0, 0, 1'b0, 5);
        run_seq(2, 1'b0, 1'b0, 0, 1'b0, 13);

        // valid held through done: second request waits for IDLE
        run_seq(0, 1'b1, 1'b1, 1, 1'b0, 5);
        run_seq(1, 1'b0, 1'b0, 0, 1'b0, 9);

        // reset during INC_HI of an addr=5 sequence
        bus.req_valid = 1'b1;
        bus.req_addr  = 10'd5;
        bus.req_ena   = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        repeat (4) tick();
        chk("pre_abort_inc", int'(ctrl_sel_inc), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_inc", int'(ctrl_sel_inc), 0);
        chk("abort_sel_rst_n", int'(ctrl_sel_rst_n), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(bus.req_ready), 0);
        chk("abort_ena", int'(ctrl_ena), 0);
        repeat (3) begin
            tick();
            chk("abort_no_done", int'(done), 0);
        end
        rst_n = 1'b1;
        tick();
        chk("rerel_ready", int'(bus.req_ready), 1);
        run_seq(1, 1'b1, 1'b0, 0, 1'b0, 9);

        run_seq(1023, 1'b1, 1'b0, 0, 1'b0, 4097);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
